// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator: horizontal/vertical counters with registered
// sync, display-enable, coordinate and event-pulse outputs, all aligned to one cycle.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 11
) (
    input  logic          pixel_clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          blank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_vblank_start;
    logic [7:0]    r_frame_cnt;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_de;
    logic          w_hs_on;
    logic          w_vs_on;
    logic [CW-1:0] w_hcnt_nxt;
    logic [CW-1:0] w_vcnt_nxt;

    // Decode the current raster position and compute the next counter values.
    always_comb begin
        w_h_last   = (r_hcnt == H_LAST);
        w_v_last   = (r_vcnt == V_LAST);
        w_de       = (r_hcnt < H_ACT_END) && (r_vcnt < V_ACT_END);
        w_hs_on    = (r_hcnt >= H_SYNC_BEG) && (r_hcnt < H_SYNC_END);
        w_vs_on    = (r_vcnt >= V_SYNC_BEG) && (r_vcnt < V_SYNC_END);
        w_hcnt_nxt = r_hcnt + ONE;
        w_vcnt_nxt = r_vcnt;
        if (w_h_last) begin
            w_hcnt_nxt = '0;
            if (w_v_last) begin
                w_vcnt_nxt = '0;
            end else begin
                w_vcnt_nxt = r_vcnt + ONE;
            end
        end else begin
            w_hcnt_nxt = r_hcnt + ONE;
        end
    end

    // Counters and output registers; with en low everything holds, pulses included.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt         <= '0;
            r_vcnt         <= '0;
            r_hs           <= ~HS_POL;
            r_vs           <= ~VS_POL;
            r_de           <= 1'b0;
            r_x            <= '0;
            r_y            <= '0;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
            r_frame_cnt    <= 8'd0;
        end else if (en) begin
            r_hcnt         <= w_hcnt_nxt;
            r_vcnt         <= w_vcnt_nxt;
            r_hs           <= w_hs_on ? HS_POL : ~HS_POL;
            r_vs           <= w_vs_on ? VS_POL : ~VS_POL;
            r_de           <= w_de;
            r_x            <= w_de ? r_hcnt : '0;
            r_y            <= w_de ? r_vcnt : '0;
            r_line_start   <= (r_hcnt == '0);
            r_frame_start  <= (r_hcnt == '0) && (r_vcnt == '0);
            r_vblank_start <= (r_hcnt == '0) && (r_vcnt == V_ACT_END);
            if (w_h_last && w_v_last) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign hs           = r_hs;
    assign vs           = r_vs;
    assign de           = r_de;
    assign blank        = ~r_de;
    assign x            = r_x;
    assign y            = r_y;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
    assign vblank_start = r_vblank_start;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of hs
- VS_POL, 0, asserted level of vs
- CW, 11, width of counters and coordinates
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- pixel_clk, in, 1, pixel clock; sole clock
- rst_n, in, 1, asynchronous active-low reset
- en, in, 1, clock enable; low freezes counters and all outputs
- hs, out, 1, horizontal sync
- vs, out, 1, vertical sync
- de, out, 1, display enable (active video)
- blank, out, 1, ~de
- x, out, CW, pixel column while de=1, else 0
- y, out, CW, pixel row while de=1, else 0
- line_start, out, 1, one-cycle pulse at column 0 of every line
- frame_start, out, 1, one-cycle pulse at column 0 of line 0
- vblank_start, out, 1, one-cycle pulse at column 0 of line V_ACTIVE
- frame_cnt, out, 8, completed-frame count, wraps 255->0
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL each fit in CW bits; there SHALL be no other clock or reset.

Function
REQ-004 Internal hcnt SHALL count 0..H_TOTAL-1 on each pixel_clk edge with en=1, wrapping to 0 (no H_TOTAL state).
REQ-005 Internal vcnt SHALL advance only when hcnt wraps, counting 0..V_TOTAL-1, wrapping to 0.
REQ-006 All outputs SHALL be registered, decoded from the pre-increment (hcnt,vcnt) of the same enabled edge: one cycle of latency, mutually aligned.
REQ-007 de SHALL be 1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE; blank SHALL equal ~de on every cycle.
REQ-008 hs SHALL equal HS_POL iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, otherwise ~HS_POL.
REQ-009 vs SHALL equal VS_POL iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (whole lines), otherwise ~VS_POL.
REQ-010 x SHALL equal hcnt and y SHALL equal vcnt when de=1; both SHALL be 0 when de=0.
REQ-011 line_start SHALL be 1 iff hcnt=0; frame_start iff hcnt=0 and vcnt=0; vblank_start iff hcnt=0 and vcnt=V_ACTIVE.
REQ-012 frame_cnt SHALL increment by 1 when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1, registered with the other outputs, modulo 256.
REQ-013 With en=0, hcnt, vcnt and every output register SHALL hold their value; pulses held high SHALL remain high until the next enabled edge; no event is skipped or duplicated across a pause.
REQ-014 Every pulse output SHALL be exactly one enabled cycle wide.

Reset
REQ-015 rst_n=0 SHALL asynchronously force hcnt=0, vcnt=0, hs=~HS_POL, vs=~VS_POL, de=0, blank=1, x=0, y=0, line_start=0, frame_start=0, vblank_start=0, frame_cnt=0, regardless of en.
REQ-016 Reset asserted mid-frame SHALL abandon the frame; after release, the first enabled edge SHALL present de=1, x=0, y=0, line_start=1, frame_start=1.

Verification (default parameters, H_TOTAL=800, V_TOTAL=525)
REQ-017 Release reset, en=1 -> first edge: frame_start=1, line_start=1, de=1, x=0, y=0; frame_start next high exactly 420000 cycles later.
REQ-018 Within a line -> de high for 640 cycles; hs=0 for exactly 96 cycles, starting 656 cycles after line_start; line_start period 800.
REQ-019 Within a frame -> vs=0 for exactly 1600 cycles, starting with line 490; vblank_start on line 480 col 0; x,y=0 whenever de=0.
REQ-020 Toggle en low for 37 cycles at hcnt=799, vcnt=524 -> all outputs frozen; on resume frame_start=1 and frame_cnt increments exactly once.
REQ-021 Run 256 frames -> frame_cnt wraps 255->0; assert rst_n=0 at line 200 col 300 -> outputs take REQ-015 values immediately, without a clock edge.
REQ-022 Re-elaborate with HS_POL=1, VS_POL=1, H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23 -> line period 1056, frame period 1056*628 cycles, sync pulses active-high.
